// File: rtl/lut_fwd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lut_fwd_arbiter_pkg
// Shared constants for the lookup-table forwarding read-port arbiter.
//   CHANNEL_NUM : number of channels encoded in a table entry
//   LUT_AW      : table address width
//   LUT_DW      : table entry width (12 control bits + one bit per channel)
//   ptr_width() : width of a requester index, at least one bit
// ---------------------------------------------------------------------------
package lut_fwd_arbiter_pkg;

    localparam int CHANNEL_NUM = 4;
    localparam int LUT_AW      = 8;
    localparam int LUT_DW      = 12 + CHANNEL_NUM;

    // Index width for n requesters; a single-bit index is kept for n == 1
    // so that the pointer never collapses to a zero-width vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_fwd_arbiter_if.sv
// ---------------------------------------------------------------------------
// lut_fwd_arbiter_if
// Requester-side bus of the forwarding arbiter, flattened per requester.
//   req_valid [NREQ]      : lookup request per requester
//   req_addr  [NREQ*AW]   : requester i address at [i*AW +: AW]
//   req_ready [NREQ]      : request accepted this cycle (one-hot or zero)
//   rsp_valid [NREQ]      : response available per requester
//   rsp_data  [NREQ*DW]   : requester i entry at [i*DW +: DW]
//   rsp_ready [NREQ]      : requester consumes its response
// Modports: master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface lut_fwd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 16
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic [NREQ-1:0]    rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/lut_fwd_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   i_elig     [N]  : eligible requesters
//   i_last     [LW] : previous winner; search starts at i_last+1
//   o_grant    [N]  : one-hot winner, or zero when nobody is eligible
//   o_grant_id [LW] : index of the winner (zero when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter
    import lut_fwd_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = ptr_width(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [LW-1:0] o_grant_id
);

    // Walk last+1, last+2, ... wrapping modulo N; the first eligible
    // port found wins and later candidates are ignored.
    always_comb begin
        int  w_idx;
        logic w_found;
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_last) + k) % N;
            if (!w_found && i_elig[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx[LW-1:0];
            end
        end
    end

endmodule

// File: rtl/lut_fwd_arbiter.sv
// ---------------------------------------------------------------------------
// lut_fwd_arbiter
// Shares the single forwarding read port of the lookup table among NREQ
// requesters. One lookup is issued per cycle at most; the address is
// registered (S1) and the combinational table output is captured one cycle
// later into the owning requester's response register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : requester bus (slave side)
//   i_hold         : freeze new grants during multi-entry table updates
//   o_fwd_rden     : table forwarding read enable
//   o_fwd_addr     : table forwarding address
//   i_fwd_rdata    : table entry at o_fwd_addr (combinational read)
//   o_lookup_cnt   : accepted lookups, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module lut_fwd_arbiter
    import lut_fwd_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = LUT_AW,
    parameter int DW   = LUT_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lut_fwd_arbiter_if.slave      bus,
    input  logic                  i_hold,
    output logic                  o_fwd_rden,
    output logic [AW-1:0]         o_fwd_addr,
    input  logic [DW-1:0]         i_fwd_rdata,
    output logic [15:0]           o_lookup_cnt
);

    localparam int LW = ptr_width(NREQ);

    logic [NREQ-1:0]    r_pending;
    logic [LW-1:0]      r_last;
    logic               r_fwd_rden;
    logic [AW-1:0]      r_fwd_addr;
    logic [LW-1:0]      r_s1_id;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [NREQ*DW-1:0] r_rsp_data;
    logic [15:0]        r_lookup_cnt;

    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_grant;
    logic [LW-1:0]      w_grant_id;
    logic               w_accept;
    logic [AW-1:0]      w_win_addr;
    logic [NREQ-1:0]    w_rsp_hs;

    // A requester with an outstanding lookup is not eligible again until
    // its response has been consumed, which also guarantees a capture and a
    // handshake never target the same port in the same cycle.
    assign w_elig   = bus.req_valid & ~r_pending & {NREQ{~i_hold}};
    assign w_accept = |w_grant;
    assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

    rr_arbiter #(
        .N  (NREQ),
        .LW (LW)
    ) u_rr_arbiter (
        .i_elig     (w_elig),
        .i_last     (r_last),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // Select the winner's address for the S1 register.
    always_comb begin
        w_win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == LW'(i)) begin
                w_win_addr = bus.req_addr[i*AW +: AW];
            end
        end
    end

    // Arbitration state: outstanding-lookup flags and round-robin pointer.
    // The pointer starts at NREQ-1 so port 0 is searched first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_last    <= LW'(NREQ - 1);
        end else begin
            r_pending <= (r_pending & ~w_rsp_hs) | w_grant;
            if (w_accept) begin
                r_last <= w_grant_id;
            end
        end
    end

    // S1: register the read address and the owner of the lookup. The
    // address is left untouched on idle cycles; only the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_rden <= 1'b0;
            r_fwd_addr <= '0;
            r_s1_id    <= '0;
        end else begin
            r_fwd_rden <= w_accept;
            if (w_accept) begin
                r_fwd_addr <= w_win_addr;
                r_s1_id    <= w_grant_id;
            end
        end
    end

    // S2: capture the table entry into the owner's response slot, and
    // retire responses on their handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_fwd_rden && (r_s1_id == LW'(i))) begin
                    r_rsp_valid[i]         <= 1'b1;
                    r_rsp_data[i*DW +: DW] <= i_fwd_rdata;
                end else if (w_rsp_hs[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Accepted-lookup counter, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lookup_cnt <= '0;
        end else if (w_accept && (r_lookup_cnt != 16'hFFFF)) begin
            r_lookup_cnt <= r_lookup_cnt + 16'd1;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign o_fwd_rden    = r_fwd_rden;
    assign o_fwd_addr    = r_fwd_addr;
    assign o_lookup_cnt  = r_lookup_cnt;

endmodule

// File: tb/tb_lut_fwd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lut_fwd_arbiter
// Directed bench for lut_fwd_arbiter with a behavioural lookup table whose
// read is combinational. Inputs change 1 time unit after a rising edge and
// outputs are sampled there or 1 unit later for the combinational ready.
// ---------------------------------------------------------------------------
module tb_lut_fwd_arbiter;
    import lut_fwd_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = LUT_AW;
    localparam int DW   = LUT_DW;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          fwdRden;
    logic [AW-1:0] fwdAddr;
    logic [DW-1:0] fwdRdata;
    logic [15:0]   lookupCnt;
    logic [DW-1:0] lutMem [0:255];

    int checkCount;
    int failCount;

    lut_fwd_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    lut_fwd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .i_hold       (hold),
        .o_fwd_rden   (fwdRden),
        .o_fwd_addr   (fwdAddr),
        .i_fwd_rdata  (fwdRdata),
        .o_lookup_cnt (lookupCnt)
    );

    // Table model: entry a holds 16'hA000|a, except entry 5 which holds 'h123.
    assign fwdRdata = lutMem[fwdAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the per-requester valid and response-ready vectors and hold.
    task automatic applyStimulus(input logic [NREQ-1:0] valid,
                                 input logic [NREQ-1:0] rspRdy,
                                 input logic h);
        bus.req_valid = valid;
        bus.rsp_ready = rspRdy;
        hold          = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        applyStimulus('0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [DW-1:0] rspSlot(input int i);
        return bus.rsp_data[i*DW +: DW];
    endfunction

    logic [NREQ-1:0] seqHoldRsp [0:9];

    initial begin
        checkCount = 0;
        failCount  = 0;
        for (int a = 0; a < 256; a++) lutMem[a] = 16'hA000 | 16'(a);
        lutMem[5] = 16'h0123;
        seqHoldRsp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                       4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

        rst_n        = 1'b0;
        bus.req_addr = '0;
        applyStimulus('0, '0, 1'b0);
        #2;
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        checkOutput("rst_fwd_rden",  32'(fwdRden),       32'h0);
        checkOutput("rst_fwd_addr",  32'(fwdAddr),       32'h0);
        checkOutput("rst_cnt",       32'(lookupCnt),     32'h0);
        applyReset();

        $display("[TB] single lookup from port 0");
        bus.req_addr = {8'h00, 8'h00, 8'h00, 8'h05};
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        #1 checkOutput("t1_ready", 32'(bus.req_ready), 32'h1);
        step();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("t1_fwd_rden", 32'(fwdRden), 32'h1);
        checkOutput("t1_fwd_addr", 32'(fwdAddr), 32'h05);
        checkOutput("t1_rsp_early", 32'(bus.rsp_valid), 32'h0);
        step();
        checkOutput("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("t1_rsp_data",  32'(rspSlot(0)),    32'h123);
        checkOutput("t1_cnt",       32'(lookupCnt),     32'h1);
        checkOutput("t1_rden_off",  32'(fwdRden),       32'h0);
        checkOutput("t1_addr_keep", 32'(fwdAddr),       32'h05);
        applyStimulus(4'b0000, 4'b0001, 1'b0);
        step();
        checkOutput("t1_rsp_clear", 32'(bus.rsp_valid), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] all ports streaming");
        applyReset();
        bus.req_addr = {8'h04, 8'h03, 8'h02, 8'h01};
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1 checkOutput($sformatf("t2_ready_%0d", c), 32'(bus.req_ready),
                           32'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                checkOutput($sformatf("t2_rsp_valid_%0d", c), 32'(bus.rsp_valid),
                            32'(4'b0001 << ((c - 2) % 4)));
                checkOutput($sformatf("t2_rsp_data_%0d", c), 32'(rspSlot((c - 2) % 4)),
                            32'(16'hA000 | 16'(((c - 2) % 4) + 1)));
            end
            step();
        end
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        repeat (3) step();
        checkOutput("t2_drained", 32'(bus.rsp_valid), 32'h0);
        checkOutput("t2_cnt",     32'(lookupCnt),     32'd10);

        $display("[TB] port 2 stalls its response");
        applyReset();
        bus.req_addr = {8'h04, 8'h03, 8'h02, 8'h01};
        applyStimulus(4'b1111, 4'b1011, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1 checkOutput($sformatf("t3_ready_%0d", c), 32'(bus.req_ready),
                           32'(seqHoldRsp[c]));
            if (c >= 4) begin
                checkOutput($sformatf("t3_p2_valid_%0d", c), 32'(bus.rsp_valid[2]), 32'h1);
                checkOutput($sformatf("t3_p2_data_%0d", c), 32'(rspSlot(2)), 32'hA003);
            end
            step();
        end
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        repeat (3) step();
        checkOutput("t3_drained", 32'(bus.rsp_valid), 32'h0);
        checkOutput("t3_cnt",     32'(lookupCnt),     32'd10);

        $display("[TB] hold after port 1 accept");
        applyReset();
        bus.req_addr = {8'h00, 8'h00, 8'h07, 8'h00};
        applyStimulus(4'b0010, 4'b1111, 1'b0);
        #1 checkOutput("t4_ready_p1", 32'(bus.req_ready), 32'h2);
        step();
        applyStimulus(4'b1001, 4'b1111, 1'b1);
        #1 checkOutput("t4_hold_ready0", 32'(bus.req_ready), 32'h0);
        checkOutput("t4_fwd_rden", 32'(fwdRden), 32'h1);
        checkOutput("t4_fwd_addr", 32'(fwdAddr), 32'h07);
        step();
        checkOutput("t4_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        checkOutput("t4_rsp_data",  32'(rspSlot(1)),    32'hA007);
        checkOutput("t4_hold_ready1", 32'(bus.req_ready), 32'h0);
        step();
        checkOutput("t4_hold_ready2", 32'(bus.req_ready), 32'h0);
        checkOutput("t4_hold_cnt",    32'(lookupCnt),     32'h1);
        applyStimulus(4'b1001, 4'b1111, 1'b0);
        #1 checkOutput("t4_resume_p3", 32'(bus.req_ready), 32'h8);
        step();
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        #1 checkOutput("t4_resume_p0", 32'(bus.req_ready), 32'h1);
        step();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        repeat (3) step();

        $display("[TB] reset with S1 in flight");
        bus.req_addr = {8'h00, 8'h00, 8'h00, 8'h05};
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        step();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        checkOutput("t5_inflight", 32'(fwdRden), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rden",  32'(fwdRden),       32'h0);
        checkOutput("t5_addr",  32'(fwdAddr),       32'h0);
        checkOutput("t5_rsp",   32'(bus.rsp_valid), 32'h0);
        checkOutput("t5_cnt",   32'(lookupCnt),     32'h0);
        step();
        checkOutput("t5_rsp_next",  32'(bus.rsp_valid), 32'h0);
        checkOutput("t5_rden_next", 32'(fwdRden),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] counter saturation");
        force dut.r_lookup_cnt = 16'hFFFE;
        #1;
        release dut.r_lookup_cnt;
        bus.req_addr = {8'h00, 8'h03, 8'h02, 8'h01};
        applyStimulus(4'b0111, 4'b1111, 1'b0);
        #1 checkOutput("t6_ready0", 32'(bus.req_ready), 32'h1);
        step();
        checkOutput("t6_cnt1", 32'(lookupCnt), 32'hFFFF);
        applyStimulus(4'b0110, 4'b1111, 1'b0);
        #1 checkOutput("t6_ready1", 32'(bus.req_ready), 32'h2);
        step();
        applyStimulus(4'b0100, 4'b1111, 1'b0);
        #1 checkOutput("t6_ready2", 32'(bus.req_ready), 32'h4);
        step();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        checkOutput("t6_cnt3", 32'(lookupCnt), 32'hFFFF);
        repeat (3) step();
        checkOutput("t6_cnt_stay", 32'(lookupCnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
